sr_reg_arbiter: RTL and testbench

SR_REG_ARBITER -- requirements
Module: sr_reg_arbiter

---
 rtl/sr_arb_pkg.sv | 27 ++
 rtl/sr_cell.sv | 39 +++
 rtl/sr_reg_arbiter.sv | 128 ++++++++++++
 tb/tb_sr_reg_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_arb_pkg.sv
// Shared definitions for the SR register-bank arbiter.
//   - command encodings {s,r} applied to one bit of the bank
//   - FSM state type and requester-select type
//   - default bank width
package sr_arb_pkg;

  localparam int unsigned N_BITS_DEFAULT = 4;

  typedef logic [1:0] cmd_t;

  localparam cmd_t CMD_HOLD    = 2'b00;
  localparam cmd_t CMD_RESET   = 2'b01;
  localparam cmd_t CMD_SET     = 2'b10;
  localparam cmd_t CMD_INVALID = 2'b11;

  typedef enum logic {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  // Identifies a requester; also used as the round-robin last-served pointer.
  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_t;

endpackage

// File: rtl/sr_cell.sv
// One synchronous SR storage bit.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-low reset, clears the bit
//   s   - set request
//   r   - reset request
//   q   - stored bit
// s=r=0 and s=r=1 both hold the bit.
module sr_cell (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (s && !r) begin
      q_d = 1'b1;
    end else if (r && !s) begin
      q_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sr_reg_arbiter.sv
// Two-requester round-robin arbiter in front of a bank of SR bits.
// A granted command is latched on the IDLE->APPLY edge and applied to
// the addressed bit on the APPLY->IDLE edge, so at most one command
// completes every two cycles.
// Ports:
//   clk            - clock, rising edge
//   rst            - synchronous active-low reset
//   req_a / req_b  - command requests
//   cmd_a / cmd_b  - commands {s,r}: 00 hold, 01 reset, 10 set, 11 invalid
//   addr_a/ addr_b - target bit index
//   gnt_a / gnt_b  - one-cycle grant, high during the APPLY cycle
//   q              - register bank state
//   busy           - high while in APPLY
//   err            - sticky, set when an invalid command is executed
module sr_reg_arbiter
  import sr_arb_pkg::*;
#(
  parameter int unsigned N_BITS = N_BITS_DEFAULT,
  parameter int unsigned ADDR_W = $clog2(N_BITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic [1:0]        cmd_a,
  input  logic [ADDR_W-1:0] addr_a,
  output logic              gnt_a,
  input  logic              req_b,
  input  logic [1:0]        cmd_b,
  input  logic [ADDR_W-1:0] addr_b,
  output logic              gnt_b,
  output logic [N_BITS-1:0] q,
  output logic              busy,
  output logic              err
);

  state_t            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  sel_t              sel_q, sel_d;
  sel_t              last_q, last_d;
  logic              err_q, err_d;

  sel_t              winner;
  logic [N_BITS-1:0] cell_s;
  logic [N_BITS-1:0] cell_r;

  // On a tie the requester not served last wins.
  always_comb begin
    if (req_a && req_b) begin
      winner = (last_q == SEL_B) ? SEL_A : SEL_B;
    end else if (req_a) begin
      winner = SEL_A;
    end else begin
      winner = SEL_B;
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
    last_d  = last_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d = APPLY;
          sel_d   = winner;
          last_d  = winner;
          cmd_d   = (winner == SEL_A) ? cmd_a : cmd_b;
          addr_d  = (winner == SEL_A) ? addr_a : addr_b;
        end
      end
      APPLY: begin
        state_d = IDLE;
        if (cmd_q == CMD_INVALID) begin
          err_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cmd_q   <= CMD_HOLD;
      addr_q  <= '0;
      sel_q   <= SEL_A;
      last_q  <= SEL_B;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Only the addressed cell sees s/r, and only during APPLY. INVALID drives
  // s=r=1, which the cell treats as hold.
  always_comb begin
    cell_s = '0;
    cell_r = '0;
    if (state_q == APPLY) begin
      cell_s[addr_q] = cmd_q[1];
      cell_r[addr_q] = cmd_q[0];
    end
  end

  for (genvar i = 0; i < N_BITS; i++) begin : g_cell
    sr_cell u_cell (
      .clk (clk),
      .rst (rst),
      .s   (cell_s[i]),
      .r   (cell_r[i]),
      .q   (q[i])
    );
  end

  assign busy  = (state_q == APPLY);
  assign gnt_a = (state_q == APPLY) && (sel_q == SEL_A);
  assign gnt_b = (state_q == APPLY) && (sel_q == SEL_B);
  assign err   = err_q;

endmodule

// File: tb/tb_sr_reg_arbiter.sv
// Directed bench for sr_reg_arbiter. Inputs change and outputs are sampled
// on the falling edge, halfway between rising edges.
module tb_sr_reg_arbiter;

  localparam int unsigned N_BITS = 4;
  localparam int unsigned ADDR_W = 2;

  logic              clk;
  logic              rst;
  logic              req_a;
  logic [1:0]        cmd_a;
  logic [ADDR_W-1:0] addr_a;
  logic              gnt_a;
  logic              req_b;
  logic [1:0]        cmd_b;
  logic [ADDR_W-1:0] addr_b;
  logic              gnt_b;
  logic [N_BITS-1:0] q;
  logic              busy;
  logic              err;

  int errors = 0;
  int checks = 0;

  sr_reg_arbiter #(
    .N_BITS (N_BITS),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req_a  (req_a),
    .cmd_a  (cmd_a),
    .addr_a (addr_a),
    .gnt_a  (gnt_a),
    .req_b  (req_b),
    .cmd_b  (cmd_b),
    .addr_b (addr_b),
    .gnt_b  (gnt_b),
    .q      (q),
    .busy   (busy),
    .err    (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Grants are mutually exclusive and busy tracks the grant in every cycle.
  always @(negedge clk) begin
    checks++;
    if ((gnt_a & gnt_b) !== 1'b0) begin
      errors++;
      $display("FAIL gnt_exclusive: gnt_a=%b gnt_b=%b, required not both high", gnt_a, gnt_b);
    end
    checks++;
    if (busy !== (gnt_a | gnt_b)) begin
      errors++;
      $display("FAIL busy_vs_gnt: busy=%b, required %b", busy, gnt_a | gnt_b);
    end
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({q, busy, gnt_a, gnt_b, err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_state: q=%b busy=%b gnt_a=%b gnt_b=%b err=%b, required all 0",
               q, busy, gnt_a, gnt_b, err);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_set_a();
    req_a = 1'b1; cmd_a = 2'b10; addr_a = 2'd2;
    @(negedge clk);
    req_a = 1'b0;
    checks++;
    if ({gnt_a, gnt_b, busy, q} !== {3'b101, 4'b0000}) begin
      errors++;
      $display("FAIL set_a_grant: gnt_a=%b gnt_b=%b busy=%b q=%b, required 1 0 1 0000",
               gnt_a, gnt_b, busy, q);
    end
    @(negedge clk);
    checks++;
    if ({gnt_a, busy, q} !== {2'b00, 4'b0100}) begin
      errors++;
      $display("FAIL set_a_result: gnt_a=%b busy=%b q=%b, required 0 0 0100", gnt_a, busy, q);
    end
  endtask

  task automatic test_tie();
    req_a = 1'b1; cmd_a = 2'b01; addr_a = 2'd2;
    req_b = 1'b1; cmd_b = 2'b10; addr_b = 2'd0;
    @(negedge clk);
    req_b = 1'b0;
    checks++;
    if ({gnt_a, gnt_b} !== 2'b01) begin
      errors++;
      $display("FAIL tie_first_b: gnt_a=%b gnt_b=%b, required 0 1", gnt_a, gnt_b);
    end
    @(negedge clk);
    checks++;
    if ({gnt_a, gnt_b, q} !== {2'b00, 4'b0101}) begin
      errors++;
      $display("FAIL tie_after_b: gnt_a=%b gnt_b=%b q=%b, required 0 0 0101", gnt_a, gnt_b, q);
    end
    @(negedge clk);
    req_a = 1'b0;
    checks++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      errors++;
      $display("FAIL tie_then_a: gnt_a=%b gnt_b=%b, required 1 0", gnt_a, gnt_b);
    end
    @(negedge clk);
    checks++;
    if (q !== 4'b0001) begin
      errors++;
      $display("FAIL tie_final_q: q=%b, required 0001", q);
    end
  endtask

  task automatic test_hold();
    req_a = 1'b1; cmd_a = 2'b00; addr_a = 2'd0;
    @(negedge clk);
    req_a = 1'b0;
    checks++;
    if (gnt_a !== 1'b1) begin
      errors++;
      $display("FAIL hold_grant: gnt_a=%b, required 1", gnt_a);
    end
    @(negedge clk);
    checks++;
    if ({q, err} !== {4'b0001, 1'b0}) begin
      errors++;
      $display("FAIL hold_result: q=%b err=%b, required 0001 0", q, err);
    end
  endtask

  task automatic test_invalid();
    req_b = 1'b1; cmd_b = 2'b11; addr_b = 2'd1;
    @(negedge clk);
    req_b = 1'b0;
    checks++;
    if ({gnt_b, err} !== 2'b10) begin
      errors++;
      $display("FAIL invalid_grant: gnt_b=%b err=%b, required 1 0", gnt_b, err);
    end
    @(negedge clk);
    checks++;
    if ({q, err} !== {4'b0001, 1'b1}) begin
      errors++;
      $display("FAIL invalid_result: q=%b err=%b, required 0001 1", q, err);
    end
    req_a = 1'b1; cmd_a = 2'b10; addr_a = 2'd1;
    @(negedge clk);
    req_a = 1'b0;
    @(negedge clk);
    checks++;
    if ({q, err} !== {4'b0011, 1'b1}) begin
      errors++;
      $display("FAIL err_sticky: q=%b err=%b, required 0011 1", q, err);
    end
  endtask

  task automatic test_back_to_back();
    logic [N_BITS-1:0] exp_q;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({q, err} !== 5'b0) begin
      errors++;
      $display("FAIL b2b_reset: q=%b err=%b, required 0000 0", q, err);
    end
    exp_q = '0;
    req_a = 1'b1; cmd_a = 2'b10; addr_a = 2'd0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (gnt_a !== ((i % 2) == 0)) begin
        errors++;
        $display("FAIL b2b_gnt_cycle%0d: gnt_a=%b, required %b", i, gnt_a, (i % 2) == 0);
      end
      if ((i % 2) == 0) begin
        // Next address is only sampled after this APPLY cycle.
        addr_a = 2'((i / 2) + 1);
      end else begin
        exp_q[i / 2] = 1'b1;
        checks++;
        if (q !== exp_q) begin
          errors++;
          $display("FAIL b2b_q_cycle%0d: q=%b, required %b", i, q, exp_q);
        end
      end
    end
    req_a = 1'b0;
    checks++;
    if (q !== 4'b1111) begin
      errors++;
      $display("FAIL b2b_final_q: q=%b, required 1111", q);
    end
  endtask

  task automatic test_reset_during_apply();
    // Make the error flag set so the reset clearing it is observable.
    req_b = 1'b1; cmd_b = 2'b11; addr_b = 2'd0;
    @(negedge clk);
    req_b = 1'b0;
    @(negedge clk);
    req_b = 1'b1; cmd_b = 2'b10; addr_b = 2'd3;
    @(negedge clk);
    req_b = 1'b0;
    checks++;
    if ({gnt_b, busy, err} !== 3'b111) begin
      errors++;
      $display("FAIL rda_apply: gnt_b=%b busy=%b err=%b, required 1 1 1", gnt_b, busy, err);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if ({q, busy, gnt_a, gnt_b, err} !== 8'h00) begin
      errors++;
      $display("FAIL rda_aborted: q=%b busy=%b gnt_a=%b gnt_b=%b err=%b, required all 0",
               q, busy, gnt_a, gnt_b, err);
    end
    @(negedge clk);
    checks++;
    if ({busy, gnt_a, gnt_b, q} !== 7'b0) begin
      errors++;
      $display("FAIL rda_idle: busy=%b gnt_a=%b gnt_b=%b q=%b, required 0 0 0 0000",
               busy, gnt_a, gnt_b, q);
    end
    // Pointer was reset to B, so A wins the first tie after B was last granted.
    req_a = 1'b1; cmd_a = 2'b00; addr_a = 2'd0;
    req_b = 1'b1; cmd_b = 2'b00; addr_b = 2'd0;
    @(negedge clk);
    req_a = 1'b0;
    req_b = 1'b0;
    checks++;
    if ({gnt_a, gnt_b} !== 2'b10) begin
      errors++;
      $display("FAIL rda_tie_a_first: gnt_a=%b gnt_b=%b, required 1 0", gnt_a, gnt_b);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_priority();
    // Request and reset in the same cycle: reset wins, no grant follows.
    req_a = 1'b1; cmd_a = 2'b10; addr_a = 2'd1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req_a = 1'b0;
    checks++;
    if ({busy, gnt_a, q} !== 6'b0) begin
      errors++;
      $display("FAIL rst_priority: busy=%b gnt_a=%b q=%b, required 0 0 0000", busy, gnt_a, q);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    req_a = 1'b0; cmd_a = 2'b00; addr_a = '0;
    req_b = 1'b0; cmd_b = 2'b00; addr_b = '0;
    @(negedge clk);
    test_reset();
    test_set_a();
    test_tie();
    test_hold();
    test_invalid();
    test_back_to_back();
    test_reset_during_apply();
    test_rst_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
